pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/pipe_decoder_pkg.sv | 36 +++
 rtl/pipe_regfile.sv | 33 +++
 rtl/pipe_decoder.sv | 149 ++++++++++++++
 tb/tb_pipe_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_decoder_pkg.sv
// pipe_decoder_pkg: opcodes, instruction field positions and defaults shared by the decoder slice
package pipe_decoder_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   localparam int OPC_LSB = 0;
   localparam int OPC_W   = 7;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RIDX_W  = 5;

   localparam logic [6:0] OP_RTYPE  = 7'h33;
   localparam logic [6:0] OP_IARITH = 7'h13;
   localparam logic [6:0] OP_ILOAD  = 7'h03;
   localparam logic [6:0] OP_STYPE  = 7'h23;
   localparam logic [6:0] OP_BTYPE  = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

   // FMT_X marks every opcode outside the supported set
   function automatic fmt_e opc_fmt(input logic [6:0] opc);
      return (opc == OP_RTYPE) ? FMT_R :
             (opc == OP_IARITH || opc == OP_ILOAD || opc == OP_JALR) ? FMT_I :
             (opc == OP_STYPE) ? FMT_S :
             (opc == OP_BTYPE) ? FMT_B :
             (opc == OP_LUI || opc == OP_AUIPC) ? FMT_U :
             (opc == OP_JAL) ? FMT_J : FMT_X;
   endfunction

endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: NREGS x XLEN register file, x0 hard-wired to zero, two bypassed read ports
module pipe_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [RW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [RW-1:0]   i_raddr1,
   input  logic [RW-1:0]   i_raddr2,
   output logic [XLEN-1:0] o_rdata1,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_mem [NREGS];
   logic            w_wr;

   assign w_wr = i_we && i_waddr != '0;

   // write port; index 0 is never written so it reads as zero forever
   always_ff @(posedge clk)
      if (rst)
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      else if (w_wr)
         r_mem[i_waddr] <= i_wdata;

   assign o_rdata1 = (w_wr && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
   assign o_rdata2 = (w_wr && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];

endmodule

// File: rtl/pipe_decoder.sv
// pipe_decoder: one-stage decoder with immediate generation, scoreboard stalls and bypassed operand read
module pipe_decoder
   import pipe_decoder_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int CNT_W = 2,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [RW-1:0]   out_rd,
   output logic            out_wen,
   output logic            out_illegal,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush
);

   fmt_e              w_fmt;
   logic [RIDX_W-1:0] w_rd_f, w_rs1_f, w_rs2_f;
   logic              w_has1, w_has2, w_hasd, w_illegal, w_use1, w_use2, w_usd, w_wen;
   logic [RW-1:0]     w_rd, w_rs1, w_rs2;
   logic [XLEN-1:0]   w_imm, w_rs1_data, w_rs2_data;
   logic              w_busy1, w_busy2, w_full, w_hazard, w_accept, w_dec;

   logic [CNT_W-1:0]  r_cnt [NREGS];
   logic              r_valid, r_wen, r_illegal;
   logic [31:0]       r_instr;
   logic [XLEN-1:0]   r_pc, r_imm, r_rs1_data, r_rs2_data;
   logic [RW-1:0]     r_rd;

   // field decode; an out-of-range index in any field the format uses makes the instruction illegal
   always_comb begin
      w_fmt     = opc_fmt(in_instr[OPC_LSB +: OPC_W]);
      w_rd_f    = in_instr[RD_LSB +: RIDX_W];
      w_rs1_f   = in_instr[RS1_LSB +: RIDX_W];
      w_rs2_f   = in_instr[RS2_LSB +: RIDX_W];
      w_has1    = w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
      w_has2    = w_fmt inside {FMT_R, FMT_S, FMT_B};
      w_hasd    = w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
      w_illegal = (w_fmt == FMT_X) ||
                  (w_has1 && int'(w_rs1_f) >= NREGS) ||
                  (w_has2 && int'(w_rs2_f) >= NREGS) ||
                  (w_hasd && int'(w_rd_f) >= NREGS);
      w_use1    = w_has1 && !w_illegal;
      w_use2    = w_has2 && !w_illegal;
      w_usd     = w_hasd && !w_illegal;
      w_rs1     = w_use1 ? w_rs1_f[RW-1:0] : '0;
      w_rs2     = w_use2 ? w_rs2_f[RW-1:0] : '0;
      w_rd      = w_usd ? w_rd_f[RW-1:0] : '0;
      w_wen     = w_usd && w_rd != '0;
   end

   // immediate generator: every format sign-extends from instruction bit 31
   always_comb
      w_imm = w_illegal ? '0 :
              (w_fmt == FMT_I) ? XLEN'($signed(in_instr[31:20])) :
              (w_fmt == FMT_S) ? XLEN'($signed({in_instr[31:25], in_instr[11:7]})) :
              (w_fmt == FMT_B) ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0})) :
              (w_fmt == FMT_U) ? XLEN'($signed({in_instr[31:12], 12'b0})) :
              (w_fmt == FMT_J) ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})) :
              '0;

   // a single outstanding writer is fine when its write-back arrives this cycle (bypass covers it)
   always_comb begin
      w_busy1  = w_use1 && (r_cnt[w_rs1] > CNT_W'(1) ||
                 (r_cnt[w_rs1] == CNT_W'(1) && !(wb_en && wb_rd == w_rs1)));
      w_busy2  = w_use2 && (r_cnt[w_rs2] > CNT_W'(1) ||
                 (r_cnt[w_rs2] == CNT_W'(1) && !(wb_en && wb_rd == w_rs2)));
      w_full   = w_wen && (&r_cnt[w_rd]);
      w_hazard = in_valid && (w_busy1 || w_busy2 || w_full);
   end

   assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush && !rst;
   assign w_accept = in_valid && in_ready;
   assign w_dec    = wb_en && wb_rd != '0 && r_cnt[wb_rd] != '0;

   pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_en),
      .i_waddr  (wb_rd),
      .i_wdata  (wb_data),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rs1_data),
      .o_rdata2 (w_rs2_data)
   );

   // pending-writer scoreboard: +1 per accepted writer, -1 per write-back, never below zero
   always_ff @(posedge clk)
      if (rst || flush)
         for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
      else
         for (int i = 0; i < NREGS; i++)
            r_cnt[i] <= r_cnt[i] + CNT_W'(w_accept && w_wen && w_rd == RW'(i))
                                 - CNT_W'(w_dec && wb_rd == RW'(i));

   // output stage: load on accept, hold while stalled, drop valid when consumed or flushed
   always_ff @(posedge clk)
      if (rst) begin
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_pc       <= '0;
         r_imm      <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_rd       <= '0;
         r_wen      <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (flush)
         r_valid <= 1'b0;
      else if (w_accept) begin
         r_valid    <= 1'b1;
         r_instr    <= in_instr;
         r_pc       <= in_pc;
         r_imm      <= w_imm;
         r_rs1_data <= w_rs1_data;
         r_rs2_data <= w_rs2_data;
         r_rd       <= w_rd;
         r_wen      <= w_wen;
         r_illegal  <= w_illegal;
      end else if (out_ready)
         r_valid <= 1'b0;

   assign out_valid    = r_valid;
   assign out_instr    = r_instr;
   assign out_pc       = r_pc;
   assign out_imm      = r_imm;
   assign out_rs1_data = r_rs1_data;
   assign out_rs2_data = r_rs2_data;
   assign out_rd       = r_rd;
   assign out_wen      = r_wen;
   assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_pipe_decoder.sv
// tb_pipe_decoder: directed scenarios plus randomized traffic against a behavioural decoder model
module tb_pipe_decoder;

   localparam logic [31:0] ADDI1 = {12'hFFB, 5'd0, 3'd0, 5'd1, 7'h13};
   localparam logic [31:0] ADD2  = {7'd0, 5'd1, 5'd1, 3'd0, 5'd2, 7'h33};
   localparam logic [31:0] ADDI3 = {12'd3, 5'd0, 3'd0, 5'd3, 7'h13};
   localparam logic [31:0] JALR4 = {12'h800, 5'd0, 3'd0, 5'd4, 7'h67};
   localparam logic [31:0] SW32  = {7'd0, 5'd3, 5'd2, 3'b010, 5'd4, 7'h23};
   localparam logic [31:0] BAD   = 32'h0000_00FF;
   localparam logic [31:0] ADDI5 = {12'd1, 5'd0, 3'd0, 5'd5, 7'h13};
   localparam logic [31:0] ADD6  = {7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33};
   localparam logic [31:0] ADDI7 = {12'd9, 5'd0, 3'd0, 5'd7, 7'h13};
   localparam logic [31:0] ILL16 = {12'd0, 5'd17, 3'd0, 5'd1, 7'h13};

   logic        clk = 0, rst = 1;
   logic        in_valid = 0, out_ready = 0, wb_en = 0, flush = 0;
   logic [31:0] in_instr = 0, in_pc = 0, wb_data = 0;
   logic [4:0]  wb_rd = 0;
   logic        in_ready, out_valid, out_wen, out_illegal;
   logic [31:0] out_instr, out_pc, out_imm, out_rs1_data, out_rs2_data;
   logic [4:0]  out_rd;

   logic        v16 = 0;
   logic [31:0] i16 = 0;
   logic        r16, ov16, ow16, oi16;
   logic [31:0] oin16, opc16, oim16, od1_16, od2_16;
   logic [3:0]  ord16;

   pipe_decoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_wen(out_wen),
      .out_illegal(out_illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
   );

   pipe_decoder #(.NREGS(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_instr(i16), .in_pc(32'd0),
      .out_valid(ov16), .out_ready(1'b1), .out_instr(oin16), .out_pc(opc16), .out_imm(oim16),
      .out_rs1_data(od1_16), .out_rs2_data(od2_16), .out_rd(ord16), .out_wen(ow16),
      .out_illegal(oi16), .wb_en(1'b0), .wb_rd(4'd0), .wb_data(32'd0), .flush(1'b0)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] imm; int rd, rs1, rs2; bit wen, ill, u1, u2; } dec_t;

   logic [31:0] m_rf [32];
   int          m_cnt [32];
   bit          m_valid = 0, m_wen = 0, m_ill = 0;
   logic [31:0] m_instr = 0, m_pc = 0, m_imm = 0, m_d1 = 0, m_d2 = 0;
   int          m_rd = 0;
   bit          m_acc, m_acc_wen;
   int          m_acc_rd;
   int          n_cmp = 0, n_bad = 0;
   int          pend [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // decoding rules written as plain arithmetic on the instruction word
   function automatic dec_t mdec(input logic [31:0] ins, input int nregs);
      dec_t d;
      int u   = int'(ins);
      int op  = u & 127;
      int rd  = (u >> 7) & 31;
      int r1  = (u >> 15) & 31;
      int r2  = (u >> 20) & 31;
      int imm = 0;
      bit hd  = 0;
      d = '{default: 0};
      case (op)
         'h33: begin d.u1 = 1; d.u2 = 1; hd = 1; end
         'h13, 'h03, 'h67: begin d.u1 = 1; hd = 1; imm = u >>> 20; end
         'h23: begin d.u1 = 1; d.u2 = 1; imm = ((u >>> 25) << 5) | rd; end
         'h63: begin
            d.u1 = 1; d.u2 = 1;
            imm = ((u >>> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
         end
         'h37, 'h17: begin hd = 1; imm = u & 32'hFFFF_F000; end
         'h6F: begin
            hd = 1;
            imm = ((u >>> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
         end
         default: d.ill = 1;
      endcase
      d.ill = d.ill || (d.u1 && r1 >= nregs) || (d.u2 && r2 >= nregs) || (hd && rd >= nregs);
      if (d.ill) begin
         d.u1 = 0;
         d.u2 = 0;
      end else begin
         d.imm = imm;
         d.wen = hd && rd != 0;
         d.rd  = hd ? rd : 0;
         d.rs1 = d.u1 ? r1 : 0;
         d.rs2 = d.u2 ? r2 : 0;
      end
      return d;
   endfunction

   function automatic bit m_busy(input int r);
      return m_cnt[r] > 1 || (m_cnt[r] == 1 && !(wb_en && int'(wb_rd) == r));
   endfunction

   function automatic logic [31:0] m_read(input int r);
      return (r == 0) ? 32'd0 : (wb_en && int'(wb_rd) == r) ? wb_data : m_rf[r];
   endfunction

   // one clock: check in_ready before the edge, advance the model, check every output after it
   task automatic cycle();
      dec_t d;
      bit   rdy;
      @(negedge clk);
      d   = mdec(in_instr, 32);
      rdy = !rst && (!m_valid || out_ready) && !flush &&
            !(in_valid && ((d.u1 && m_busy(d.rs1)) || (d.u2 && m_busy(d.rs2)) || (d.wen && m_cnt[d.rd] == 3)));
      chk("in_ready", 64'(in_ready), 64'(rdy));
      m_acc = in_valid && rdy;
      m_acc_rd = d.rd;
      m_acc_wen = d.wen;
      if (rst) begin
         m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_wen = 0; m_ill = 0;
         for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_cnt[i] = 0; end
      end else begin
         if (m_acc) begin
            m_instr = in_instr; m_pc = in_pc; m_imm = d.imm; m_d1 = m_read(d.rs1); m_d2 = m_read(d.rs2);
            m_rd = d.rd; m_wen = d.wen; m_ill = d.ill;
         end
         m_valid = flush ? 0 : m_acc ? 1 : out_ready ? 0 : m_valid;
         if (flush)
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         else begin
            if (wb_en && wb_rd != '0 && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
            if (m_acc && d.wen) m_cnt[d.rd]++;
         end
         if (wb_en && wb_rd != '0) m_rf[wb_rd] = wb_data;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_instr", 64'(out_instr), 64'(m_instr));
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_imm", 64'(out_imm), 64'(m_imm));
      chk("out_rs1_data", 64'(out_rs1_data), 64'(m_d1));
      chk("out_rs2_data", 64'(out_rs2_data), 64'(m_d2));
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_wen", 64'(out_wen), 64'(m_wen));
      chk("out_illegal", 64'(out_illegal), 64'(m_ill));
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F, 7'h73};
      logic [31:0] r = $urandom;
      r[6:0]   = ops[$urandom_range(10)];
      r[11:7]  = 5'($urandom_range(7));
      r[19:15] = 5'($urandom_range(7));
      r[24:20] = 5'($urandom_range(7));
      return r;
   endfunction

   initial begin
      // reset
      rst = 1;
      cycle();
      cycle();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_imm", 64'(out_imm), 64'(0));
      rst = 0;

      // addi x1,x0,-5
      out_ready = 1; in_valid = 1; in_instr = ADDI1; in_pc = 32'h100;
      cycle();
      chk("addi_imm", 64'(out_imm), 64'(32'hFFFF_FFFB));
      chk("addi_rd", 64'(out_rd), 64'(1));
      chk("addi_wen", 64'(out_wen), 64'(1));
      chk("cnt_x1_after_addi", 64'(dut.r_cnt[1]), 64'(1));

      // add x2,x1,x1 stalls on x1 until its write-back, then issues with bypassed data
      in_instr = ADD2; in_pc = 32'h104;
      cycle();
      chk("add_stall_valid", 64'(out_valid), 64'(0));
      cycle();
      cycle();
      wb_en = 1; wb_rd = 5'd1; wb_data = 32'd7;
      cycle();
      chk("add_rs1_bypass", 64'(out_rs1_data), 64'(7));
      chk("add_rs2_bypass", 64'(out_rs2_data), 64'(7));
      chk("cnt_x1_after_wb", 64'(dut.r_cnt[1]), 64'(0));
      wb_en = 0;

      // downstream stall for three cycles with a pending instruction
      out_ready = 0; in_instr = ADDI3; in_pc = 32'h108;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("stall_hold_instr", 64'(out_instr), 64'(ADD2));
      end
      out_ready = 1;
      cycle();
      chk("stall_release_instr", 64'(out_instr), 64'(ADDI3));

      // jalr with imm 0x800
      in_instr = JALR4; in_pc = 32'h10C;
      cycle();
      chk("jalr_imm", 64'(out_imm), 64'(32'hFFFF_F800));

      // retire x2 and x3, then sw x3,4(x2)
      in_valid = 0; wb_en = 1; wb_rd = 5'd2; wb_data = 32'd14;
      cycle();
      wb_rd = 5'd3; wb_data = 32'd3;
      cycle();
      wb_en = 0; in_valid = 1; in_instr = SW32; in_pc = 32'h110;
      cycle();
      chk("sw_wen", 64'(out_wen), 64'(0));
      chk("sw_imm", 64'(out_imm), 64'(4));
      chk("sw_rs1", 64'(out_rs1_data), 64'(14));
      chk("sw_rs2", 64'(out_rs2_data), 64'(3));
      chk("cnt_x3_after_sw", 64'(dut.r_cnt[3]), 64'(0));

      // unsupported opcode, and rs1 = 17 on the 16-register instance
      in_instr = BAD; in_pc = 32'h114; v16 = 1; i16 = ILL16;
      cycle();
      chk("bad_illegal", 64'(out_illegal), 64'(1));
      chk("bad_wen", 64'(out_wen), 64'(0));
      chk("bad_imm", 64'(out_imm), 64'(0));
      chk("n16_valid", 64'(ov16), 64'(1));
      chk("n16_illegal", 64'(oi16), 64'(1));
      chk("n16_wen", 64'(ow16), 64'(0));
      v16 = 0;

      // three writers to x5, a fourth blocked at the counter maximum, then flush
      in_instr = ADDI5;
      for (int k = 0; k < 3; k++) cycle();
      chk("cnt_x5_full", 64'(dut.r_cnt[5]), 64'(3));
      cycle();
      flush = 1;
      cycle();
      flush = 0;
      chk("flush_cnt_x5", 64'(dut.r_cnt[5]), 64'(0));
      chk("flush_valid", 64'(out_valid), 64'(0));
      in_instr = ADD6;
      cycle();
      chk("post_flush_issue_valid", 64'(out_valid), 64'(1));
      chk("post_flush_issue_instr", 64'(out_instr), 64'(ADD6));

      // reset while an entry is held in a stall
      out_ready = 0; in_instr = ADDI7;
      cycle();
      rst = 1;
      cycle();
      rst = 0;
      chk("rst_stall_valid", 64'(out_valid), 64'(0));
      chk("rst_stall_instr", 64'(out_instr), 64'(0));
      chk("rst_cnt_x6", 64'(dut.r_cnt[6]), 64'(0));
      in_valid = 0;
      cycle();

      // randomized traffic with an in-order retirement queue
      for (int k = 0; k < 1500; k++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         in_instr  = rand_instr();
         in_pc     = $urandom;
         flush     = ($urandom_range(39) == 0);
         wb_en     = 0;
         wb_rd     = 0;
         wb_data   = $urandom;
         if (pend.size() > 0 && $urandom_range(2) == 0) begin
            wb_en = 1;
            wb_rd = 5'(pend.pop_front());
         end else if ($urandom_range(9) == 0) begin
            wb_en = 1;
            wb_rd = 5'($urandom_range(7));
         end
         cycle();
         if (flush) pend.delete();
         else if (m_acc && m_acc_wen) pend.push_back(m_acc_rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
